aes_subbytes_seq: RTL



---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_subbytes_seq_if.sv | 21 ++
 rtl/aes_sbox_bram.sv | 37 +++
 rtl/aes_subbytes_seq.sv | 103 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: word sizes, SubBytes FSM encoding and byte indexing.
package aes_pkg;

    localparam int unsigned AES_BYTES      = 16;
    localparam int unsigned AES_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } aes_state_e;

    // Bit offset of byte idx in an nbytes-wide word, byte 0 being the most significant.
    function automatic int unsigned byte_lsb(int unsigned nbytes, int unsigned idx);
        return 8 * (nbytes - 1 - idx);
    endfunction

endpackage

// File: rtl/aes_subbytes_seq_if.sv
// Input and output valid/ready channels of the sequential SubBytes engine.
interface aes_subbytes_seq_if #(
    parameter int unsigned NBYTES = 16
);
    logic [8*NBYTES-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [8*NBYTES-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/aes_sbox_bram.sv
// AES forward S-box as a ROM with a registered output (one cycle read latency).
module aes_sbox_bram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    output logic [7:0] dout
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] dout_q, dout_d;

    // Entry 0 sits in the top byte, so ~addr selects it counting from the bottom.
    always_comb begin
        dout_d = SBOX[{~addr, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 8'h00;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential SubBytes: streams a state word byte by byte through one registered S-box.
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned NBYTES = AES_BYTES
) (
    input  logic                clk,
    input  logic                rst,
    aes_subbytes_seq_if.slave   bus,
    output logic                busy
);

    localparam int unsigned     CNT_W   = $clog2(NBYTES + 1);
    localparam int unsigned     DW      = 8 * NBYTES;
    localparam int unsigned     IDX_W   = $clog2(DW);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NBYTES);

    aes_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    in_buf_q, in_buf_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       sbox_addr, sbox_dout;
    logic [IDX_W-1:0] rd_lsb, wr_lsb;
    logic             rst_n;

    // Read runs one byte ahead of write because of the S-box register; indices are
    // clamped where the corresponding access is unused.
    always_comb begin
        rd_lsb = IDX_W'(byte_lsb(NBYTES, (cnt_q < CntLast) ? 32'(cnt_q) : 32'd0));
        wr_lsb = IDX_W'(byte_lsb(NBYTES, (cnt_q != '0) ? 32'(cnt_q) - 32'd1 : 32'd0));
    end

    assign sbox_addr = in_buf_q[rd_lsb +: 8];
    assign rst_n     = ~rst;

    aes_sbox_bram u_sbox (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (sbox_addr),
        .dout  (sbox_dout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_buf_d    = in_buf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    in_buf_d = bus.in_data;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    out_data_d[wr_lsb +: 8] = sbox_dout;
                end
                if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            in_buf_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_buf_q    <= in_buf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q == StRun) || (state_q == StDone);

endmodule
